// File: rtl/hamming_best_tracker.sv
// Hamming-distance best tracker: 3-stage popcount pipeline plus running-minimum/hit record.
// Optional candidate counter enabled by defining HAMMING_CAND_CNT_EN.
module hamming_best_tracker #(
  parameter int NONCE_W   = 64,
  parameter int THRESHOLD = 400
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [1023:0]      key_i,
  input  logic [1023:0]      hash_i,
  input  logic [NONCE_W-1:0] nonce_i,
  input  logic               valid_i,
  input  logic               clear_i,
  output logic [10:0]        best_dist_o,
  output logic [NONCE_W-1:0] best_nonce_o,
  output logic               best_update_o,
  output logic               hit_o,
  output logic [NONCE_W-1:0] hit_nonce_o,
  output logic [47:0]        cand_cnt_o
);

  localparam int LANES = 16;
  localparam logic [10:0] DIST_SENTINEL = 11'h7FF;

  logic [1023:0]      w_x;
  logic [6:0]         w_lane_cnt [LANES];
  logic [10:0]        w_dist_sum;
  logic               w_update;
  logic               w_hit;

  logic [6:0]         r_s1_cnt [LANES];
  logic [NONCE_W-1:0] r_s1_nonce;
  logic               r_s1_valid;

  logic [10:0]        r_s2_dist;
  logic [NONCE_W-1:0] r_s2_nonce;
  logic               r_s2_valid;

  logic [10:0]        r_best_dist;
  logic [NONCE_W-1:0] r_best_nonce;
  logic               r_best_update;
  logic               r_hit;
  logic [NONCE_W-1:0] r_hit_nonce;

  assign w_x = hash_i ^ key_i;

  // Popcount each 64-bit lane independently; the per-lane counts are what stage 1 registers.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [6:0] w_cnt;
      always_comb begin
        w_cnt = '0;
        for (int b = 0; b < 64; b++) begin
          w_cnt = w_cnt + 7'(w_x[gi*64 + b]);
        end
      end
      assign w_lane_cnt[gi] = w_cnt;
    end
  endgenerate

  always_comb begin
    w_dist_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      w_dist_sum = w_dist_sum + 11'(r_s1_cnt[i]);
    end
  end

  // Stage 3 compares against the registered best, so a back-to-back successor sees its predecessor's update.
  assign w_update = r_s2_valid && (r_s2_dist < r_best_dist);
  assign w_hit    = r_s2_valid && (r_s2_dist <= 11'(THRESHOLD)) && !r_hit;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < LANES; i++) r_s1_cnt[i] <= '0;
      r_s1_nonce <= '0;
      r_s1_valid <= 1'b0;
      r_s2_dist  <= '0;
      r_s2_nonce <= '0;
      r_s2_valid <= 1'b0;
    end else begin
      for (int i = 0; i < LANES; i++) r_s1_cnt[i] <= w_lane_cnt[i];
      r_s1_nonce <= nonce_i;
      r_s1_valid <= valid_i && !clear_i;
      r_s2_dist  <= w_dist_sum;
      r_s2_nonce <= r_s1_nonce;
      r_s2_valid <= r_s1_valid && !clear_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_best_dist   <= DIST_SENTINEL;
      r_best_nonce  <= '0;
      r_best_update <= 1'b0;
      r_hit         <= 1'b0;
      r_hit_nonce   <= '0;
    end else if (clear_i) begin
      r_best_dist   <= DIST_SENTINEL;
      r_best_nonce  <= '0;
      r_best_update <= 1'b0;
      r_hit         <= 1'b0;
      r_hit_nonce   <= '0;
    end else begin
      r_best_update <= w_update;
      if (w_update) begin
        r_best_dist  <= r_s2_dist;
        r_best_nonce <= r_s2_nonce;
      end
      if (w_hit) begin
        r_hit       <= 1'b1;
        r_hit_nonce <= r_s2_nonce;
      end
    end
  end

`ifdef HAMMING_CAND_CNT_EN
  logic [47:0] r_cand_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cand_cnt <= '0;
    end else if (clear_i) begin
      r_cand_cnt <= '0;
    end else if (r_s2_valid && (r_cand_cnt != '1)) begin
      r_cand_cnt <= r_cand_cnt + 48'd1;
    end
  end

  assign cand_cnt_o = r_cand_cnt;
`else
  assign cand_cnt_o = '0;
`endif

  assign best_dist_o   = r_best_dist;
  assign best_nonce_o  = r_best_nonce;
  assign best_update_o = r_best_update;
  assign hit_o         = r_hit;
  assign hit_nonce_o   = r_hit_nonce;

endmodule

// File: tb/tb_hamming_best_tracker.sv
// Directed bench for hamming_best_tracker: hand-computed distances checked after the 3-cycle latency.
module tb_hamming_best_tracker;

  localparam int NONCE_W = 64;

  logic               clk_i = 1'b0;
  logic               rst_n_i = 1'b0;
  logic [1023:0]      key_i;
  logic [1023:0]      hash_i = '0;
  logic [NONCE_W-1:0] nonce_i = '0;
  logic               valid_i = 1'b0;
  logic               clear_i = 1'b0;
  logic [10:0]        best_dist_o;
  logic [NONCE_W-1:0] best_nonce_o;
  logic               best_update_o;
  logic               hit_o;
  logic [NONCE_W-1:0] hit_nonce_o;
  logic [47:0]        cand_cnt_o;

  int total = 0;
  int bad = 0;
  int upd_cnt = 0;
  logic [47:0] exp_cnt;

  hamming_best_tracker #(.NONCE_W(NONCE_W), .THRESHOLD(400)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .key_i(key_i), .hash_i(hash_i),
    .nonce_i(nonce_i), .valid_i(valid_i), .clear_i(clear_i),
    .best_dist_o(best_dist_o), .best_nonce_o(best_nonce_o),
    .best_update_o(best_update_o), .hit_o(hit_o), .hit_nonce_o(hit_nonce_o),
    .cand_cnt_o(cand_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    if (best_update_o) upd_cnt++;
  endtask

  function automatic logic [1023:0] low_ones(input int n);
    logic [1023:0] m;
    m = '0;
    for (int i = 0; i < n; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Present one candidate for a single cycle, then wait until its result is visible.
  task automatic send(input logic [1023:0] h, input logic [63:0] n);
    hash_i = h; nonce_i = n; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    upd_cnt = 0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) key_i[i*32 +: 32] = $urandom;
    #23 rst_n_i = 1'b1;
    tick();

    chk("rst_best_dist", 64'(best_dist_o), 64'h7FF);
    chk("rst_best_nonce", best_nonce_o, 64'd0);
    chk("rst_update", 64'(best_update_o), 64'd0);
    chk("rst_hit", 64'(hit_o), 64'd0);
    chk("rst_hit_nonce", hit_nonce_o, 64'd0);
    chk("rst_cnt", 64'(cand_cnt_o), 64'd0);

    // Exact match: distance 0
    upd_cnt = 0;
    send(key_i, 64'd5);
    chk("eq_update_pulse", 64'(best_update_o), 64'd1);
    chk("eq_dist", 64'(best_dist_o), 64'd0);
    chk("eq_nonce", best_nonce_o, 64'd5);
    chk("eq_hit", 64'(hit_o), 64'd1);
    chk("eq_hit_nonce", hit_nonce_o, 64'd5);
    tick(); tick();
    chk("eq_update_drop", 64'(best_update_o), 64'd0);
    chk("eq_upd_count", 64'(upd_cnt), 64'd1);

    // Complement (1024) then distance 1
    do_clear();
    chk("clr_dist", 64'(best_dist_o), 64'h7FF);
    chk("clr_hit", 64'(hit_o), 64'd0);
    send(~key_i, 64'd1);
    chk("inv_dist", 64'(best_dist_o), 64'd1024);
    chk("inv_update", 64'(best_update_o), 64'd1);
    chk("inv_hit", 64'(hit_o), 64'd0);
    send(key_i ^ 1024'h1, 64'd2);
    chk("d1_dist", 64'(best_dist_o), 64'd1);
    chk("d1_nonce", best_nonce_o, 64'd2);
    chk("d1_hit_nonce", hit_nonce_o, 64'd2);

    // Back-to-back 600, 300, 300, 700: tie keeps nonce 11
    do_clear();
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: hash_i = key_i ^ low_ones(600);
        1: hash_i = key_i ^ low_ones(300);
        2: hash_i = key_i ^ ~low_ones(724);
        default: hash_i = key_i ^ low_ones(700);
      endcase
      nonce_i = 64'(10 + i);
      valid_i = 1'b1;
      tick();
    end
    valid_i = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("b2b_dist", 64'(best_dist_o), 64'd300);
    chk("b2b_nonce", best_nonce_o, 64'd11);
    chk("b2b_hit_nonce", hit_nonce_o, 64'd11);
    chk("b2b_upd_count", 64'(upd_cnt), 64'd2);

    // Bit 63 of each lane, then lane 15 fully set
    do_clear();
    hash_i = key_i;
    for (int l = 0; l < 16; l++) hash_i[l*64 + 63] = ~hash_i[l*64 + 63];
    send(hash_i, 64'd20);
    chk("lane_msb_dist", 64'(best_dist_o), 64'd16);
    do_clear();
    hash_i = key_i;
    hash_i[1023:960] = ~hash_i[1023:960];
    send(hash_i, 64'd21);
    chk("lane15_dist", 64'(best_dist_o), 64'd64);
    chk("lane15_hit", 64'(hit_o), 64'd1);

    // Clear while two candidates are in flight
    do_clear();
    hash_i = key_i; nonce_i = 64'd30; valid_i = 1'b1;
    tick();
    nonce_i = 64'd31;
    tick();
    valid_i = 1'b0; clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("flush_dist", 64'(best_dist_o), 64'h7FF);
    chk("flush_hit", 64'(hit_o), 64'd0);
    chk("flush_upd_count", 64'(upd_cnt), 64'd0);
    send(key_i ^ low_ones(512), 64'd32);
    chk("post_flush_dist", 64'(best_dist_o), 64'd512);
    chk("post_flush_nonce", best_nonce_o, 64'd32);

    // Candidate counter over 20 back-to-back candidates
    do_clear();
    for (int i = 0; i < 20; i++) begin
      hash_i = key_i ^ low_ones(i + 3);
      nonce_i = 64'(100 + i);
      valid_i = 1'b1;
      tick();
    end
    valid_i = 1'b0;
    tick(); tick();
`ifdef HAMMING_CAND_CNT_EN
    exp_cnt = 48'd20;
`else
    exp_cnt = 48'd0;
`endif
    chk("cnt_after_20", 64'(cand_cnt_o), 64'(exp_cnt));
    chk("cnt_best_dist", 64'(best_dist_o), 64'd3);
    chk("cnt_best_nonce", best_nonce_o, 64'd100);
    do_clear();
    chk("cnt_after_clear", 64'(cand_cnt_o), 64'd0);
    chk("cnt_clear_dist", 64'(best_dist_o), 64'h7FF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hamming_best_tracker.md
Name: hamming_best_tracker

Overview:
- Sits directly downstream of the Skein-1024 hash core and of the 1024-bit target-key constant.
- Per accepted candidate it computes the Hamming distance between the hash and the key, using a 3-stage pipeline.
- Keeps the running minimum distance and the nonce that produced it, and flags any candidate at or below a threshold.
- The host/UART layer reads its results.

Parameters:
- NONCE_W, 64, width of the candidate identifier that travels with each hash.
- THRESHOLD, 400, distance at or below which hit_o is set.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  asynchronous active-low reset.
- key_i  in  1024  target key; static, driven by the key constant block.
- hash_i  in  1024  hash result for the candidate.
- nonce_i  in  NONCE_W  candidate identifier paired with hash_i.
- valid_i  in  1  hash_i/nonce_i valid this cycle.
- clear_i  in  1  synchronous flush: drop in-flight candidates and reset the best record.
- best_dist_o  out  11  minimum distance seen so far.
- best_nonce_o  out  NONCE_W  nonce of best_dist_o.
- best_update_o  out  1  one-cycle pulse when the best record changes.
- hit_o  out  1  sticky; set when any distance <= THRESHOLD.
- hit_nonce_o  out  NONCE_W  nonce of the first hit.
- cand_cnt_o  out  48  candidates evaluated (optional feature).

Behaviour:
- Reset (async, rst_n_i=0):
  - best_dist_o=11'h7FF (sentinel above max 1024); best_nonce_o=0.
  - best_update_o=0; hit_o=0; hit_nonce_o=0; cand_cnt_o=0.
  - All pipeline valid bits=0.
- Flow control: no backpressure. The block accepts one candidate every cycle that valid_i=1; there is no ready signal.
- Stage 1 (S1): registers x=hash_i^key_i as 16 lanes of 64 bits. Lane popcounts are 7 bits each (0..64). Registers nonce and valid.
- Stage 2 (S2): sums the 16 lane counts into an 11-bit distance (0..1024). No overflow is possible. Registers nonce and valid.
- Stage 3 (S3), compare/update, when S2 valid=1:
  - Update condition: dist < best_dist_o, strict, so ties keep the earlier nonce.
  - On update: best_dist_o<=dist, best_nonce_o<=nonce, best_update_o<=1 for one cycle.
  - Hit condition: dist <= THRESHOLD and hit_o=0.
  - On hit: hit_o<=1, hit_nonce_o<=nonce.
  - hit_o stays 1 until reset or clear_i.
- Latency: valid_i at cycle N -> best_* / hit_* registered at the end of cycle N+2, visible in cycle N+3.
- Back-to-back candidates:
  - Each is compared against best_dist_o as already updated by its predecessor.
  - Forwarding is inherent because S3 is one stage and compares the registered best each cycle.
  - A better candidate following a worse one in the next cycle is handled correctly.
- First valid candidate always updates, since max dist 1024 < sentinel 2047.
- clear_i=1:
  - Next cycle: all pipeline valids=0, best_* back to reset values, hit_o=0, hit_nonce_o=0, best_update_o=0.
  - cand_cnt_o=0.
  - valid_i in the same cycle as clear_i is dropped.
  - A candidate entering the cycle after clear_i deasserts is processed normally.
- key_i must be stable; changing it mid-run applies from S1 onward for new candidates only.

Optional Feature:
- Macro: HAMMING_CAND_CNT_EN.
- Defined:
  - cand_cnt_o increments by 1 each cycle S3 valid=1.
  - Saturates at 2^48-1.
  - Cleared by reset and clear_i.
- Undefined:
  - No counter logic; cand_cnt_o is tied to 0.
  - All other behaviour is identical.

Test Plan:
- Reset, then a single valid_i with hash_i=key_i, nonce=5 -> 3 cycles later: best_dist_o=0, best_nonce_o=5, best_update_o pulses once, hit_o=1, hit_nonce_o=5.
- hash_i=~key_i, nonce=1 -> best_dist_o=1024, best_update_o=1, hit_o=0. Then hash_i=key_i^1024'h1 (dist 1), nonce=2 -> best_dist_o=1, best_nonce_o=2.
- Back-to-back cycles with distances 600, 300, 300, 700 (nonces 10..13) -> best_dist_o=300, best_nonce_o=11, hit_nonce_o=11, exactly two best_update_o pulses.
- Per-lane check: hash_i=key_i with bit 63 of every lane flipped (16 bits) -> best_dist_o=16. Also all ones in lane 15 only -> 64.
- clear_i asserted while 2 candidates are in flight -> neither updates; best_dist_o=11'h7FF, hit_o=0. The next candidate with dist 512 -> best_dist_o=512.
- With HAMMING_CAND_CNT_EN: 20 valid candidates, then clear_i -> cand_cnt_o=20, then 0. Without the macro, cand_cnt_o=0 throughout.
